debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Parameterised multi-bit switch/button debouncer.
- Each of Count independent asynchronous inputs is synchronised to clk. The corresponding output bit changes only after the synchronised input has held a value different from the current output for Period consecutive clock cycles.
- Sits between raw board I/O (buttons, switches) and synchronous core logic.

Parameters:
- Count, 1, number of independent input/output bits (≥1).
- Period, 10, number of consecutive stable cycles required before an output bit changes (≥1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_i  input  Count  raw, possibly bouncing, asynchronous inputs; bit n independent of all others.
- sig_o  output  Count  debounced, clk-synchronous outputs; registered.

Behaviour:
- Every bit is processed identically and independently. There is no cross-bit interaction; simultaneous changes on several bits are handled in parallel.
- Per-bit state:
  - 2-flop synchroniser s1/s2 (see Optional Feature).
  - Counter cnt, width $clog2(Period+1).
  - Output register out (drives sig_o[n]).
- Reset (rst=1 at rising edge): s1=0, s2=0, cnt=0, sig_o=0 for all bits. Reset has priority over all other updates. Reset asserted mid-count discards the count; after reset, sig_o=0 regardless of sig_i.
- Each rising edge without reset:
  - s1<=sig_i[n], s2<=s1.
  - If s2==out: cnt<=0.
  - Else if cnt==Period-1: out<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
- Latency (sync enabled): a clean level change on sig_i[n] that is stable before rising edge k (edge k samples it into s1) appears on sig_o[n] after rising edge k+1+Period. That is, Period+2 edges including edge k.
- Glitch rejection: any return of s2 to the current out value before cnt reaches Period-1 clears cnt. Pulses/gaps shorter than Period cycles (as seen at s2) never reach sig_o.
- Period=1: output follows s2 with one extra register stage, no filtering.
- cnt never exceeds Period-1; no wrap-around possible.
- sig_o is glitch-free (driven directly from flops).

Optional Feature:
- Macro: DEBOUNCER_SYNC_EN.
- Defined: 2-flop synchroniser per bit as described; latency Period+2 edges.
- Not defined: s1/s2 removed; the counter compares sig_i[n] directly (sig_i must be already synchronous to clk). Latency is Period edges: a change stable before edge k appears after edge k+Period-1. All other rules are unchanged.

Decomposition:
- No shared package required; no typedefs.
- Counter width is a localparam computed from Period inside the block.
- One natural sub-module, debounce_bit: synchroniser + counter + output flop for a single bit, parameterised by Period. debouncer instantiates Count copies via a generate loop.

Test Plan:
All scenarios use Count=2, Period=10, 10 ns clock, sync enabled, and apply rst for 2 cycles first.
1. Reset: drive sig_i=2'b11 while rst=1 -> sig_o=2'b00 throughout reset and for 11 edges after release; sig_o becomes 2'b11 exactly 12 edges after the first sampling edge post-reset.
2. Clean rise: sig_a 0->1 held -> sig_o[0] rises after exactly 12 rising edges (sync 2 + Period 10); sig_o[1] stays 0.
3. Glitch rejection: sig_b high for 3 cycles then low -> sig_o[1] never leaves 0; internal cnt returns to 0.
4. Bounce then settle: sig_a toggles every 2 cycles for 8 cycles, then holds 1 -> sig_o[0] rises 12 edges after the final transition, with no intermediate changes.
5. Independence: sig_a falls and sig_b rises on the same edge -> sig_o[0] falls and sig_o[1] rises on the same edge, 12 edges later.
6. Mid-count reset: sig_a held 1 for 8 cycles, then rst pulsed 1 cycle with sig_a still 1 -> sig_o[0] stays 0 until 12 edges after reset release.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared helpers for the debouncer block.
package debouncer_pkg;

    // Counter width needed to hold values 0 .. period-1 with headroom.
    function automatic int cnt_width(input int period);
        return (period < 2) ? 1 : $clog2(period + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: optional 2-flop synchroniser, stability counter and output flop.
// Macro DEBOUNCER_SYNC_EN enables the synchroniser; otherwise sig_i must already be clk-synchronous.
module debounce_bit
    import debouncer_pkg::*;
#(
    parameter int Period = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sig_o
);

    localparam int CNT_W = cnt_width(Period);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Period - 1);

    logic             cmp;
    logic [CNT_W-1:0] cnt;
    logic             out;

`ifdef DEBOUNCER_SYNC_EN
    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_i;
            s2 <= s1;
        end
    end

    assign cmp = s2;
`else
    assign cmp = sig_i;
`endif

    // Any return to the current output level before the count completes restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (cmp == out) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            out <= cmp;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sig_o = out;

endmodule

// File: rtl/debouncer.sv
// Multi-bit switch/button debouncer: Count independent copies of debounce_bit.
// Macro DEBOUNCER_SYNC_EN adds a 2-flop input synchroniser to every bit.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int Count  = 1,
    parameter int Period = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Count-1:0] sig_i,
    output logic [Count-1:0] sig_o
);

    for (genvar n = 0; n < Count; n++) begin : g_bit
        debounce_bit #(
            .Period(Period)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .sig_i(sig_i[n]),
            .sig_o(sig_o[n])
        );
    end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: directed step table plus randomized stimulus against a window-based reference model.
module tb_debouncer;

    localparam int COUNT  = 2;
    localparam int PERIOD = 10;
`ifdef DEBOUNCER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT  = PERIOD + SYNC;
    localparam int MAXE = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [COUNT-1:0] sig_i = '0;
    logic [COUNT-1:0] sig_o;

    always #5 clk = ~clk;

    debouncer #(
        .Count (COUNT),
        .Period(PERIOD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sig_i(sig_i),
        .sig_o(sig_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an output bit flips once the value it sees has differed
    // from it on each of the last PERIOD edges, all after the latest reset.
    logic [COUNT-1:0] hist [MAXE];
    int               edge_n   = 0;
    int               last_rst = -1000;
    logic [COUNT-1:0] mout     = '0;
    bit               mvalid   = 0;

    function automatic logic seen(input int t, input int b);
        if (t - SYNC > last_rst) return hist[t - SYNC][b];
        return 1'b0;
    endfunction

    function automatic bit window_flip(input int b);
        if (edge_n - PERIOD + 1 <= last_rst) return 0;
        for (int k = 0; k < PERIOD; k++)
            if (seen(edge_n - k, b) == mout[b]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget: edge %0d required below %0d", edge_n, MAXE);
            $fatal(1);
        end
        hist[edge_n] = sig_i;
        if (rst) begin
            last_rst = edge_n;
            mout     = '0;
            mvalid   = 1;
        end else begin
            for (int b = 0; b < COUNT; b++)
                if (window_flip(b)) mout[b] = ~mout[b];
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (sig_o !== mout) begin
                errors++;
                $display("FAIL model edge %0d: sig_o=%b required %b", edge_n, sig_o, mout);
            end
        end
    end

    typedef struct {
        logic             r;
        logic [COUNT-1:0] s;
        int               n;
        logic [COUNT-1:0] e;
        string            name;
    } step_t;

    step_t steps[$];

    task automatic add(input logic r, input logic [COUNT-1:0] s, input int n,
                       input logic [COUNT-1:0] e, input string name);
        step_t st;
        st.r = r; st.s = s; st.n = n; st.e = e; st.name = name;
        steps.push_back(st);
    endtask

    int hold [COUNT];

    initial begin
        add(1, 2'b11, 2,       2'b00, "reset_hold");
        add(0, 2'b11, LAT - 1, 2'b00, "reset_release_wait");
        add(0, 2'b11, 1,       2'b11, "reset_release_rise");
        add(0, 2'b00, LAT - 1, 2'b11, "fall_wait");
        add(0, 2'b00, 1,       2'b00, "fall_done");
        add(0, 2'b01, LAT - 1, 2'b00, "clean_rise_wait");
        add(0, 2'b01, 1,       2'b01, "clean_rise");
        add(0, 2'b01, 5,       2'b01, "clean_rise_hold");
        add(0, 2'b11, 3,       2'b01, "glitch_pulse");
        add(0, 2'b01, LAT + 3, 2'b01, "glitch_rejected");
        add(0, 2'b00, LAT,     2'b00, "bounce_prep");
        add(0, 2'b01, 2,       2'b00, "bounce_1");
        add(0, 2'b00, 2,       2'b00, "bounce_2");
        add(0, 2'b01, 2,       2'b00, "bounce_3");
        add(0, 2'b00, 2,       2'b00, "bounce_4");
        add(0, 2'b01, LAT - 1, 2'b00, "settle_wait");
        add(0, 2'b01, 1,       2'b01, "settle_rise");
        add(0, 2'b10, LAT - 1, 2'b01, "indep_wait");
        add(0, 2'b10, 1,       2'b10, "indep_swap");
        add(0, 2'b00, LAT,     2'b00, "midrst_prep");
        add(0, 2'b01, 8,       2'b00, "midrst_count");
        add(1, 2'b01, 1,       2'b00, "midrst_pulse");
        add(0, 2'b01, LAT - 1, 2'b00, "midrst_wait");
        add(0, 2'b01, 1,       2'b01, "midrst_rise");

        @(negedge clk);
        foreach (steps[i]) begin
            rst   = steps[i].r;
            sig_i = steps[i].s;
            repeat (steps[i].n) @(negedge clk);
            #1;
            checks++;
            if (sig_o !== steps[i].e) begin
                errors++;
                $display("FAIL %s: sig_o=%b required %b", steps[i].name, sig_o, steps[i].e);
            end
        end

        rst = 1'b0;
        for (int b = 0; b < COUNT; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < COUNT; b++) begin
                if (hold[b] == 0) begin
                    sig_i[b] = 1'($urandom_range(0, 1));
                    hold[b]  = $urandom_range(1, 2 * PERIOD + 4);
                end
                hold[b]--;
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
